// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Decode-stage forwarding select, load-use interlock and stall counter
//            tracking the EX/MEM/WB destination slots.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int ADDR_SIZE = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic                 D_we,
    input  logic                 D_ld,
    input  logic                 mem_stall,
    input  logic                 EX_flush,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 D_stall,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [ADDR_SIZE-1:0] rd;
    } slot_t;

    slot_t            ex_q, mem_q, wb_q, ex_d;
    // The load flag only matters while the load occupies EX.
    logic             ex_ld_q, ex_ld_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [1:0] w_use;
    logic [1:0] w_ex_hit, w_mem_hit, w_wb_hit;
    logic       w_live;
    logic       w_load_use;
    logic       w_stall;

    function automatic logic slot_hit(input slot_t s, input logic live,
                                      input logic [ADDR_SIZE-1:0] src);
        return live & s.valid & s.we & (s.rd != '0) & (s.rd == src);
    endfunction

    // Slots read as empty while reset is held.
    assign w_live = ~rst;
    assign w_use  = {D_use_ra, D_use_rb} & {2{D_valid}};

    assign w_ex_hit  = w_use & {slot_hit(ex_q,  w_live, D_ra), slot_hit(ex_q,  w_live, D_rb)};
    assign w_mem_hit = w_use & {slot_hit(mem_q, w_live, D_ra), slot_hit(mem_q, w_live, D_rb)};
    assign w_wb_hit  = w_use & {slot_hit(wb_q,  w_live, D_ra), slot_hit(wb_q,  w_live, D_rb)};

    assign EX_D_bp  = w_ex_hit & ~{2{ex_ld_q}};
    assign MEM_D_bp = w_mem_hit & ~w_ex_hit;
    assign WB_D_bp  = w_wb_hit & ~w_ex_hit & ~w_mem_hit;

    assign w_load_use = ex_ld_q & (|w_ex_hit);
    assign w_stall    = mem_stall | (w_load_use & ~EX_flush);
    assign D_stall    = w_stall;
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        ex_d    = '0;
        ex_ld_d = 1'b0;
        if (!(EX_flush || w_load_use || !D_valid)) begin
            ex_d.valid = 1'b1;
            ex_d.we    = D_we;
            ex_d.rd    = D_rd;
            ex_ld_d    = D_ld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_ld_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (!mem_stall) begin
                wb_q    <= mem_q;
                mem_q   <= ex_q;
                ex_q    <= ex_d;
                ex_ld_q <= ex_ld_d;
            end
            if (w_stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire
